// File: rtl/call_pkg.sv
// Shared encodings for the call controller: UI commands, network packet
// types, controller states and the packet descriptor held in the TX slot.
package call_pkg;

  // UI command codes; values 5-7 are reserved and fall through as no-ops.
  typedef enum logic [2:0] {
    CMD_INIT_SIGNAL = 3'd0,
    CMD_MAKE_CALL   = 3'd1,
    CMD_ACCEPT      = 3'd2,
    CMD_REJECT      = 3'd3,
    CMD_END_CALL    = 3'd4
  } cmd_e;

  // Network packet types, shared by the TX and RX sides.
  typedef enum logic [2:0] {
    PKT_INIT     = 3'd0,
    PKT_CALL_REQ = 3'd1,
    PKT_CALL_ACK = 3'd2,
    PKT_CALL_REJ = 3'd3,
    PKT_CALL_END = 3'd4
  } pkt_e;

  // Controller states; the encoding is exported on the status port.
  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_IDLE      = 3'd1,
    ST_DIALING   = 3'd2,
    ST_RINGING   = 3'd3,
    ST_CONNECTED = 3'd4
  } state_e;

  localparam logic [7:0] BROADCAST = 8'hFF;

  // One outgoing packet: its type and destination address.
  typedef struct packed {
    pkt_e       kind;
    logic [7:0] dest;
  } pkt_t;

  localparam pkt_t PKT_NONE = '{kind: PKT_INIT, dest: 8'h00};

  function automatic pkt_t make_pkt(input pkt_e kind, input logic [7:0] dest);
    make_pkt = '{kind: kind, dest: dest};
  endfunction

endpackage

// File: rtl/call_tx_slot.sv
// Single-entry outgoing packet register. A load is captured only when the
// slot is empty; a load that arrives while a packet is still pending is
// dropped. The packet is presented until the cycle with tx_valid && tx_ready.
module call_tx_slot
  import call_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_valid,
  input  pkt_t load_pkt,
  input  logic tx_ready,
  output logic tx_valid,
  output pkt_t tx_pkt
);

  logic valid_q, valid_d;
  pkt_t pkt_q, pkt_d;

  // Next-slot logic: retire on handshake, otherwise accept a load when empty.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (valid_q) begin
      if (tx_ready) begin
        valid_d = 1'b0;
      end
    end else if (load_valid) begin
      valid_d = 1'b1;
      pkt_d   = load_pkt;
    end
  end

  // Slot register; reset drops a pending packet without a handshake.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (reset) begin
      valid_q <= 1'b0;
      pkt_q   <= PKT_NONE;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_pkt   = pkt_q;

endmodule

// File: rtl/call_control.sv
// Per-node call controller. Accepts UI commands, reacts to received network
// packets, runs the call state machine with a ring/answer timeout, and hands
// outgoing packets to a single-entry TX slot.
module call_control
  import call_pkg::*;
#(
  parameter logic [7:0]  MY_ADDR        = 8'h01,
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000,
  parameter int unsigned CNT_W          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] command,
  input  logic [7:0] address,
  output logic       cmd_ready,
  output logic       init,
  output logic       incoming_call,
  output logic [7:0] inc_address,
  output logic       call_active,
  output logic [2:0] status,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] tx_type,
  output logic [7:0] tx_dest,
  input  logic       rx_valid,
  input  logic [2:0] rx_type,
  input  logic [7:0] rx_src
);

  // The counter reads TIMEOUT_CYCLES-1 during the last cycle spent in the
  // timed state, so the state lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       peer_q, peer_d;
  logic [7:0]       inc_address_q, inc_address_d;
  logic             init_q, init_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             incoming_call_q, incoming_call_d;
  logic             call_active_q, call_active_d;

  logic cmd_fire;
  logic rx_fire;
  logic rx_from_peer;
  logic in_call;
  logic busy_req;
  logic timeout;
  logic load_valid;
  pkt_t load_pkt;
  pkt_t tx_pkt;

  // A command is taken only when nothing is pending on TX and no packet is
  // arriving, so a command-generated packet always finds the slot empty.
  assign cmd_ready = !tx_valid && !rx_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Our own packets echoed back by the network are never acted on.
  assign rx_fire      = rx_valid && (rx_src != MY_ADDR);
  assign rx_from_peer = rx_fire && (rx_src == peer_q);

  assign in_call  = state_q inside {ST_DIALING, ST_RINGING, ST_CONNECTED};
  assign busy_req = in_call && rx_fire && (rx_type == PKT_CALL_REQ) && (rx_src != peer_q);
  assign timeout  = (state_q inside {ST_DIALING, ST_RINGING}) && (cnt_q == CNT_LAST);

  // Next-state, peer tracking and outgoing packet selection.
  // Priority within a state: received packet, then command, then timeout.
  always_comb begin
    state_d       = state_q;
    peer_d        = peer_q;
    inc_address_d = inc_address_q;
    init_d        = init_q;
    load_valid    = 1'b0;
    load_pkt      = PKT_NONE;

    case (state_q)
      ST_UNINIT: begin
        if (cmd_fire && command == CMD_INIT_SIGNAL) begin
          load_valid = 1'b1;
          load_pkt   = make_pkt(PKT_INIT, BROADCAST);
          state_d    = ST_IDLE;
          init_d     = 1'b1;
        end else if (rx_fire && rx_type == PKT_INIT) begin
          state_d = ST_IDLE;
          init_d  = 1'b1;
        end
      end

      ST_IDLE: begin
        if (cmd_fire && command == CMD_MAKE_CALL &&
            address != MY_ADDR && address != BROADCAST) begin
          peer_d     = address;
          load_valid = 1'b1;
          load_pkt   = make_pkt(PKT_CALL_REQ, address);
          state_d    = ST_DIALING;
        end else if (rx_fire && rx_type == PKT_CALL_REQ) begin
          peer_d        = rx_src;
          inc_address_d = rx_src;
          state_d       = ST_RINGING;
        end
      end

      ST_DIALING: begin
        if (rx_from_peer && rx_type == PKT_CALL_ACK) begin
          state_d = ST_CONNECTED;
        end else if (rx_from_peer && rx_type == PKT_CALL_REJ) begin
          state_d = ST_IDLE;
        end else if ((cmd_fire && command == CMD_END_CALL) || timeout) begin
          load_valid = 1'b1;
          load_pkt   = make_pkt(PKT_CALL_END, peer_q);
          state_d    = ST_IDLE;
        end
      end

      ST_RINGING: begin
        if (rx_from_peer && rx_type == PKT_CALL_END) begin
          state_d = ST_IDLE;
        end else if (cmd_fire && command == CMD_ACCEPT) begin
          load_valid = 1'b1;
          load_pkt   = make_pkt(PKT_CALL_ACK, peer_q);
          state_d    = ST_CONNECTED;
        end else if ((cmd_fire && command == CMD_REJECT) || timeout) begin
          load_valid = 1'b1;
          load_pkt   = make_pkt(PKT_CALL_REJ, peer_q);
          state_d    = ST_IDLE;
        end
      end

      ST_CONNECTED: begin
        if (rx_from_peer && rx_type == PKT_CALL_END) begin
          state_d = ST_IDLE;
        end else if (cmd_fire && command == CMD_END_CALL) begin
          load_valid = 1'b1;
          load_pkt   = make_pkt(PKT_CALL_END, peer_q);
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_UNINIT;
      end
    endcase

    // A third party calling while we are busy gets an immediate reject. If a
    // timeout lands on the same cycle it still changes state, but the reject
    // claims the single packet slot.
    if (busy_req) begin
      load_valid = 1'b1;
      load_pkt   = make_pkt(PKT_CALL_REJ, rx_src);
    end
  end

  // Timeout counter: cleared on every state change, counts in timed states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {ST_DIALING, ST_RINGING}) begin
      cnt_d = cnt_q + 1'b1;
    end
    incoming_call_d = (state_d == ST_RINGING);
    call_active_d   = (state_d == ST_CONNECTED);
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_UNINIT;
      peer_q          <= 8'h00;
      inc_address_q   <= 8'h00;
      init_q          <= 1'b0;
      cnt_q           <= '0;
      incoming_call_q <= 1'b0;
      call_active_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      peer_q          <= peer_d;
      inc_address_q   <= inc_address_d;
      init_q          <= init_d;
      cnt_q           <= cnt_d;
      incoming_call_q <= incoming_call_d;
      call_active_q   <= call_active_d;
    end
  end

  call_tx_slot u_tx_slot (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_pkt   (load_pkt),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_pkt     (tx_pkt)
  );

  assign tx_type       = tx_pkt.kind;
  assign tx_dest       = tx_pkt.dest;
  assign status        = state_q;
  assign init          = init_q;
  assign incoming_call = incoming_call_q;
  assign call_active   = call_active_q;
  assign inc_address   = inc_address_q;

endmodule

// File: tb/tb_call_control.sv
// Bench for call_control: directed call scenarios followed by random traffic.
// A reference model advanced once per cycle predicts the visible state and
// pushes each packet it expects onto a queue; a separate monitor pops the
// queue on every TX handshake.
module tb_call_control;

  localparam int         TMO = 10;
  localparam logic [7:0] ME  = 8'h01;

  // Model state codes and packet kinds as plain numbers.
  localparam int S_UNINIT = 0, S_IDLE = 1, S_DIAL = 2, S_RING = 3, S_CONN = 4;
  localparam int P_INIT = 0, P_REQ = 1, P_ACK = 2, P_REJ = 3, P_END = 4;
  localparam int C_INIT = 0, C_CALL = 1, C_ACCEPT = 2, C_REJECT = 3, C_END = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] command = 3'd0;
  logic [7:0] address = 8'h00;
  logic       cmd_ready;
  logic       init;
  logic       incoming_call;
  logic [7:0] inc_address;
  logic       call_active;
  logic [2:0] status;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [2:0] tx_type;
  logic [7:0] tx_dest;
  logic       rx_valid = 1'b0;
  logic [2:0] rx_type = 3'd0;
  logic [7:0] rx_src = 8'h00;

  always #5 clk = ~clk;

  call_control #(
    .MY_ADDR        (ME),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (25)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .command       (command),
    .address       (address),
    .cmd_ready     (cmd_ready),
    .init          (init),
    .incoming_call (incoming_call),
    .inc_address   (inc_address),
    .call_active   (call_active),
    .status        (status),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_type       (tx_type),
    .tx_dest       (tx_dest),
    .rx_valid      (rx_valid),
    .rx_type       (rx_type),
    .rx_src        (rx_src)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         kind;
    logic [7:0] dest;
  } exp_t;

  exp_t       exp_q[$];
  int         m_state = S_UNINIT;
  int         m_age   = 0;    // cycles spent in the current state
  bit         m_init  = 1'b0;
  bit         m_txv   = 1'b0; // a packet is waiting for its handshake
  logic [7:0] m_peer  = 8'h00;
  logic [7:0] m_inc   = 8'h00;

  // One clock cycle: compare visible outputs to the model, apply inputs,
  // advance the model by the call rules, then let the edge happen.
  task automatic step(input bit rst, input bit cv, input logic [2:0] cmd, input logic [7:0] addr,
                      input bit rv, input logic [2:0] rt, input logic [7:0] rs, input bit tr);
    bit         fire, rx, from_peer, tmo, want;
    int         ns, wk;
    logic [7:0] wd;

    check("status", status, m_state);
    check("init", init, m_init);
    check("incoming_call", incoming_call, m_state == S_RING);
    check("call_active", call_active, m_state == S_CONN);
    check("inc_address", inc_address, m_inc);
    check("tx_valid", tx_valid, m_txv);

    reset = rst; cmd_valid = cv; command = cmd; address = addr;
    rx_valid = rv; rx_type = rt; rx_src = rs; tx_ready = tr;
    #1;
    check("cmd_ready", cmd_ready, !m_txv && !rv);

    if (rst) begin
      m_state = S_UNINIT; m_age = 0; m_init = 0; m_txv = 0;
      m_peer = 8'h00; m_inc = 8'h00;
      exp_q.delete();
    end else begin
      fire      = cv && !m_txv && !rv;
      rx        = rv && (rs != ME);
      from_peer = rx && (rs == m_peer);
      tmo       = (m_state == S_DIAL || m_state == S_RING) && (m_age == TMO - 1);
      ns = m_state; want = 0; wk = 0; wd = 8'h00;
      case (m_state)
        S_UNINIT: begin
          if (fire && cmd == C_INIT) begin ns = S_IDLE; m_init = 1; want = 1; wk = P_INIT; wd = 8'hFF; end
          else if (rx && rt == P_INIT) begin ns = S_IDLE; m_init = 1; end
        end
        S_IDLE: begin
          if (fire && cmd == C_CALL && addr != ME && addr != 8'hFF) begin
            ns = S_DIAL; m_peer = addr; want = 1; wk = P_REQ; wd = addr;
          end else if (rx && rt == P_REQ) begin
            ns = S_RING; m_peer = rs; m_inc = rs;
          end
        end
        S_DIAL: begin
          if (from_peer && rt == P_ACK) ns = S_CONN;
          else if (from_peer && rt == P_REJ) ns = S_IDLE;
          else if ((fire && cmd == C_END) || tmo) begin ns = S_IDLE; want = 1; wk = P_END; wd = m_peer; end
        end
        S_RING: begin
          if (from_peer && rt == P_END) ns = S_IDLE;
          else if (fire && cmd == C_ACCEPT) begin ns = S_CONN; want = 1; wk = P_ACK; wd = m_peer; end
          else if ((fire && cmd == C_REJECT) || tmo) begin ns = S_IDLE; want = 1; wk = P_REJ; wd = m_peer; end
        end
        S_CONN: begin
          if (from_peer && rt == P_END) ns = S_IDLE;
          else if (fire && cmd == C_END) begin ns = S_IDLE; want = 1; wk = P_END; wd = m_peer; end
        end
        default: ns = S_UNINIT;
      endcase
      if (m_state >= S_DIAL && rx && rt == P_REQ && rs != m_peer) begin
        want = 1; wk = P_REJ; wd = rs;
      end
      if (m_txv) begin
        if (tr) m_txv = 0;
      end else if (want) begin
        m_txv = 1;
        exp_q.push_back('{kind: wk, dest: wd});
      end
      if (ns != m_state) m_age = 0;
      else if (m_state == S_DIAL || m_state == S_RING) m_age++;
      m_state = ns;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit tr);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, tr);
  endtask

  task automatic do_cmd(input int c, input logic [7:0] a, input bit tr);
    step(0, 1, 3'(c), a, 0, 3'd0, 8'h00, tr);
  endtask

  task automatic do_rx(input int t, input logic [7:0] s, input bit tr);
    step(0, 0, 3'd0, 8'h00, 1, 3'(t), s, tr);
  endtask

  // ---------------- TX monitor ----------------
  initial begin
    exp_t       e;
    bit         hold = 0;
    logic [2:0] hold_type = 3'd0;
    logic [7:0] hold_dest = 8'h00;
    forever begin
      @(negedge clk);
      if (hold && tx_valid) begin
        check("tx_type_hold", tx_type, hold_type);
        check("tx_dest_hold", tx_dest, hold_dest);
      end
      hold      = tx_valid && !tx_ready && !reset;
      hold_type = tx_type;
      hold_dest = tx_dest;
      if (tx_valid && tx_ready && !reset) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got type %0d dest 0x%0h, expected no packet", tx_type, tx_dest);
        end else begin
          e = exp_q.pop_front();
          check("tx_type", tx_type, e.kind);
          check("tx_dest", tx_dest, e.dest);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pool [6] = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'hFF};

  initial begin
    int drain;
    @(posedge clk);
    #1;

    // Reset, then init with the network stalled for three cycles.
    step(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
    do_cmd(C_INIT, 8'h00, 0);
    check("plan_init_status", status, S_IDLE);
    check("plan_init_flag", init, 1);
    idle(3, 0);
    idle(2, 1);

    // Outgoing call accepted by 05, then hung up locally.
    do_cmd(C_CALL, 8'h05, 1);
    check("plan_dial_status", status, S_DIAL);
    idle(2, 1);
    do_rx(P_ACK, 8'h05, 1);
    check("plan_call_active", call_active, 1);
    do_cmd(C_END, 8'h00, 1);
    check("plan_end_status", status, S_IDLE);
    idle(2, 1);

    // Incoming call from 07, accepted.
    do_rx(P_REQ, 8'h07, 1);
    check("plan_incoming", incoming_call, 1);
    check("plan_inc_addr", inc_address, 8'h07);
    do_cmd(C_ACCEPT, 8'h00, 1);
    check("plan_accept_status", status, S_CONN);
    idle(2, 1);

    // Third party 09 calls while connected: rejected, state kept.
    do_rx(P_REQ, 8'h09, 1);
    check("plan_busy_status", status, S_CONN);
    idle(2, 1);
    do_cmd(C_END, 8'h00, 1);
    idle(2, 1);

    // Unanswered call to 03 times out after exactly TMO cycles in DIALING.
    do_cmd(C_CALL, 8'h03, 1);
    idle(TMO - 1, 1);
    check("plan_tmo_last_cycle", status, S_DIAL);
    idle(1, 1);
    check("plan_tmo_status", status, S_IDLE);
    idle(2, 1);

    // ACK arriving on the timeout cycle takes priority.
    do_cmd(C_CALL, 8'h03, 1);
    idle(TMO - 1, 1);
    do_rx(P_ACK, 8'h03, 1);
    check("plan_ack_wins", status, S_CONN);

    // Reset while connected with a packet pending.
    do_rx(P_REQ, 8'h09, 0);
    check("plan_pending_before_reset", tx_valid, 1);
    step(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
    check("plan_reset_status", status, S_UNINIT);
    check("plan_reset_txv", tx_valid, 0);
    check("plan_reset_init", init, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 249) == 0),
           ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)),
           pool[$urandom_range(0, 5)],
           ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 5)),
           pool[$urandom_range(0, 5)],
           ($urandom_range(0, 2) != 0));
    end

    // Drain the last outstanding packet (bounded).
    drain = 0;
    while ((exp_q.size() != 0 || tx_valid) && drain < 20) begin
      idle(1, 1);
      drain++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
